accum_responder: RTL and testbench



---
 rtl/accum_pkg.sv | 19 +
 rtl/accum_alu.sv | 31 +++
 rtl/accum_responder.sv | 89 ++++++++
 tb/tb_accum_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator responder and its ALU.
package accum_pkg;

  localparam int unsigned CountWidth = 8;

  typedef enum logic [1:0] {
    OpAdd   = 2'd0,
    OpSub   = 2'd1,
    OpClear = 2'd2,
    OpRead  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_t;

endpackage

// File: rtl/accum_alu.sv
// Combinational accumulator update; the extra top bit carries carry/borrow out.
module accum_alu
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] arg,
  output logic             ovf,
  output logic [WIDTH-1:0] next_acc
);

  logic [WIDTH:0] res;

  always_comb begin
    res = {1'b0, acc};
    unique case (op)
      OpAdd:   res = {1'b0, acc} + {1'b0, arg};
      // Two's-complement difference sets bit WIDTH exactly when arg > acc.
      OpSub:   res = {1'b0, acc} - {1'b0, arg};
      OpClear: res = '0;
      OpRead:  res = {1'b0, acc};
      default: res = {1'b0, acc};
    endcase
  end

  assign ovf      = res[WIDTH];
  assign next_acc = res[WIDTH-1:0];

endmodule

// File: rtl/accum_responder.sv
// Request/response accumulator: accept a command, execute it, hold the result until taken.
module accum_responder
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ARG_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ARG_WIDTH-1:0]  req_arg,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_ovf,
  output logic                  ovf_sticky,
  output logic [CountWidth-1:0] op_count
);

  state_t                state_q;
  op_t                   op_q;
  logic [ARG_WIDTH-1:0]  arg_q;
  logic [WIDTH-1:0]      acc_q;
  logic [WIDTH-1:0]      rsp_data_q;
  logic                  rsp_ovf_q;
  logic                  ovf_sticky_q;
  logic [CountWidth-1:0] op_count_q;

  logic [WIDTH-1:0]      alu_acc;
  logic                  alu_ovf;

  accum_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op      (op_q),
    .acc     (acc_q),
    .arg     (WIDTH'(arg_q)),
    .ovf     (alu_ovf),
    .next_acc(alu_acc)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= OpAdd;
      arg_q        <= '0;
      acc_q        <= '0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q       <= op_t'(req_op);
            arg_q      <= req_arg;
            op_count_q <= op_count_q + CountWidth'(1);
            state_q    <= StExec;
          end
        end
        StExec: begin
          acc_q        <= alu_acc;
          rsp_data_q   <= alu_acc;
          rsp_ovf_q    <= alu_ovf;
          ovf_sticky_q <= (op_q == OpClear) ? 1'b0 : (ovf_sticky_q | alu_ovf);
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs depend on state only, never on req_valid/rsp_ready.
  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign rsp_data   = rsp_data_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign ovf_sticky = ovf_sticky_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_accum_responder.sv
// Randomised self-checking bench for accum_responder against an arithmetic reference model.
module tb_accum_responder;
  import accum_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [7:0]  req_arg = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_ovf;
  logic        ovf_sticky;
  logic [7:0]  op_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_acc = 0;
  bit m_sticky = 1'b0;
  int m_count = 0;

  accum_responder #(
    .WIDTH    (16),
    .ARG_WIDTH(8)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_arg   (req_arg),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .ovf_sticky(ovf_sticky),
    .op_count  (op_count)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic void model_reset();
    m_acc = 0;
    m_sticky = 1'b0;
    m_count = 0;
  endfunction

  // Applies one accepted command to the model, returning the expected response.
  function automatic void model_apply(input int op, input int arg, output int exp_d,
                                      output bit exp_o);
    int t;
    exp_o = 1'b0;
    case (op)
      0: begin
        t = m_acc + arg;
        exp_o = (t > 65535);
        m_acc = t % 65536;
      end
      1: begin
        exp_o = (arg > m_acc);
        m_acc = exp_o ? (m_acc + 65536 - arg) : (m_acc - arg);
      end
      2: m_acc = 0;
      default: ;
    endcase
    if (op == 2) m_sticky = 1'b0;
    else m_sticky = m_sticky | exp_o;
    m_count = (m_count + 1) % 256;
    exp_d = m_acc;
  endfunction

  // Drives one full transaction; lat counts cycles from accept edge to rsp_valid.
  task automatic issue(input int op, input int arg, output int d, output bit o,
                       output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    @(negedge clock);
    req_op = 2'(op);
    req_arg = 8'(arg);
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_arg = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    d = int'(rsp_data);
    o = rsp_ovf;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    model_reset();
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got ready=%b valid=%b, expected ready=1 valid=0",
               req_ready, rsp_valid);
    end
    checks++;
    if (rsp_data !== 16'h0 || rsp_ovf !== 1'b0 || ovf_sticky !== 1'b0 || op_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs: got data=%h ovf=%b sticky=%b count=%0d, expected zeros",
               rsp_data, rsp_ovf, ovf_sticky, op_count);
    end
    @(negedge clock);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_add();
    int d, lat, ed;
    bit o, ok, eo;
    int args[2] = '{72, 36};
    foreach (args[k]) begin
      issue(0, args[k], d, o, lat, ok);
      model_apply(0, args[k], ed, eo);
      checks++;
      if (!ok || d != ed || o != eo) begin
        errors++;
        $display("FAIL basic_add%0d: got ok=%b data=%0d ovf=%b, expected data=%0d ovf=%b",
                 k, ok, d, o, ed, eo);
      end
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL basic_latency%0d: got %0d cycles, expected 2", k, lat);
      end
    end
    checks++;
    if (op_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL basic_count: got %0d, expected %0d", op_count, m_count);
    end
  endtask

  task automatic test_wrap();
    int d, lat, ed;
    bit o, ok, eo;
    int ops[4] = '{2, 1, 0, 2};
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], 1, d, o, lat, ok);
      model_apply(ops[k], 1, ed, eo);
      checks++;
      if (!ok || d != ed || o != eo || ovf_sticky !== m_sticky) begin
        errors++;
        $display("FAIL wrap_step%0d: got data=%h ovf=%b sticky=%b, expected data=%h ovf=%b sticky=%b",
                 k, d, o, ovf_sticky, ed, eo, m_sticky);
      end
    end
  endtask

  task automatic test_backpressure();
    int d, lat, ed, waited;
    bit o, ok, eo, stable;
    issue(2, 0, d, o, lat, ok);
    model_apply(2, 0, ed, eo);
    @(negedge clock);
    req_op = 2'd0;
    req_arg = 8'd5;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    req_arg = 8'd9;
    model_apply(0, 5, ed, eo);
    waited = 0;
    while (!rsp_valid && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_data !== 16'(ed) || req_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL backpressure_hold: got valid=%b data=%0d ready=%b, expected 1/%0d/0",
               rsp_valid, rsp_data, req_ready, ed);
    end
    checks++;
    if (op_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL backpressure_noaccept: got count=%0d, expected %0d", op_count, m_count);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    model_apply(0, 9, ed, eo);
    waited = 0;
    while (!rsp_valid && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'(ed)) begin
      errors++;
      $display("FAIL backpressure_next: got valid=%b data=%0d, expected 1/%0d",
               rsp_valid, rsp_data, ed);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_read();
    int d, lat, ed;
    bit o, ok, eo;
    int ops[5] = '{2, 0, 0, 3, 3};
    for (int k = 0; k < 5; k++) begin
      issue(ops[k], 200, d, o, lat, ok);
      model_apply(ops[k], 200, ed, eo);
      if (k >= 3) begin
        checks++;
        if (!ok || d != ed || o != eo) begin
          errors++;
          $display("FAIL read%0d: got data=%0d ovf=%b, expected data=%0d ovf=%b",
                   k, d, o, ed, eo);
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    int d, lat, ed;
    bit o, ok, eo, seen;
    @(negedge clock);
    req_op = 2'd0;
    req_arg = 8'd50;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (req_ready !== 1'b1 || op_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b count=%0d, expected 1/0", req_ready, op_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_drop: got rsp_valid=1, expected no response");
    end
    issue(3, 0, d, o, lat, ok);
    model_apply(3, 0, ed, eo);
    checks++;
    if (!ok || d != ed || op_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL reset_read: got data=%0d count=%0d, expected data=%0d count=%0d",
               d, op_count, ed, m_count);
    end
  endtask

  task automatic test_count_wrap();
    int d, lat, ed;
    bit o, ok, eo;
    do_reset();
    for (int i = 0; i < 255; i++) begin
      issue(3, 0, d, o, lat, ok);
      model_apply(3, 0, ed, eo);
    end
    checks++;
    if (op_count !== 8'(m_count) || m_count != 255) begin
      errors++;
      $display("FAIL count_255: got %0d, expected 255", op_count);
    end
    issue(3, 0, d, o, lat, ok);
    model_apply(3, 0, ed, eo);
    checks++;
    if (op_count !== 8'(m_count) || m_count != 0) begin
      errors++;
      $display("FAIL count_wrap: got %0d, expected 0", op_count);
    end
  endtask

  task automatic test_random();
    int d, lat, ed, op, arg, bad;
    bit o, ok, eo;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 9) < 4) ? 0 : ($urandom_range(0, 9) < 8 ? 1 : $urandom_range(2, 3));
      arg = $urandom_range(0, 255);
      issue(op, arg, d, o, lat, ok);
      model_apply(op, arg, ed, eo);
      checks++;
      if (!ok || d != ed || o != eo || ovf_sticky !== m_sticky || op_count !== 8'(m_count)
          || lat != 2) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL random%0d op=%0d arg=%0d: got data=%0d ovf=%b sticky=%b cnt=%0d lat=%0d, expected data=%0d ovf=%b sticky=%b cnt=%0d lat=2",
                   i, op, arg, d, o, ovf_sticky, op_count, lat, ed, eo, m_sticky, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_wrap();
    test_backpressure();
    test_read();
    test_reset_in_flight();
    test_count_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
